// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default operand width and the FSM state
// encoding used by both the sequential multiplier and the divider.
package arith_pkg;

    localparam int unsigned ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : arith_pkg

// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add unsigned multiplier, P = A * B, one multiplier
// bit per clock with a start/busy/done handshake (N+2 cycles per result).
module multiplicador_seq
    import arith_pkg::*;
#(
    parameter int unsigned N = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic [2*N-1:0]   P,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(N + 1);

    state_t          state_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   mcand_q;
    logic [N-1:0]    mplier_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   acc_sum_c;

    // Partial-product accumulation; PW bits always hold (2^N-1)^2.
    always_comb begin
        acc_sum_c = acc_q;
        if (mplier_q[0]) begin
            acc_sum_c = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            P        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        mcand_q  <= PW'(A);
                        mplier_q <= B;
                        acc_q    <= '0;
                        cnt_q    <= CW'(N);
                        busy     <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_sum_c;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    // Last bit: publish the completed sum directly.
                    if (cnt_q == CW'(1)) begin
                        P       <= acc_sum_c;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule : multiplicador_seq

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq: directed scenarios plus random
// operands compared against plain integer multiplication.
module tb_multiplicador_seq;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic [2*N-1:0] p_out;
    logic           busy;
    logic           done;

    int checks;
    int failures;

    multiplicador_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .P     (p_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operation before a rising edge; start drops after it unless held.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Watch one operation from the accepting edge until busy falls (bounded).
    // Cycle c is sampled on the falling edge after edge E_c (E0 = accept).
    task automatic observe(input bit poke, input logic [2*N-1:0] p_prev,
                           output int busy_cyc, output int done_cnt, output int done_idx,
                           output logic [2*N-1:0] p_done, output bit p_stable);
        busy_cyc = 0;
        done_cnt = 0;
        done_idx = -1;
        p_done   = 'x;
        p_stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (poke && c == 1) begin
                start = 1'b1;
                a_in  = 4'd7;
                b_in  = 4'd7;
            end
            if (poke && c == 3) start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_idx = c;
                p_done   = p_out;
            end else if (busy && p_out !== p_prev) begin
                p_stable = 1'b0;
            end
            if (!busy && c > 0) break;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (p_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values P=%0d busy=%b done=%b required P=0 busy=0 done=0",
                     p_out, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    // Single operation with full latency/handshake checks against a*b.
    task automatic test_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit poke);
        int bc, dc, di;
        logic [2*N-1:0] pd, prev, exp_p;
        bit ps;
        prev  = p_out;
        exp_p = (2*N)'(int'(a) * int'(b));
        launch(a, b, 1'b0);
        observe(poke, prev, bc, dc, di, pd, ps);
        checks++;
        if (pd !== exp_p) begin
            failures++;
            $display("FAIL %s_product got=%0d required=%0d", name, pd, exp_p);
        end
        checks++;
        if (dc != 1 || di != int'(N)) begin
            failures++;
            $display("FAIL %s_done pulses=%0d at_cycle=%0d required 1 at %0d", name, dc, di, N);
        end
        checks++;
        if (bc != int'(N) + 1) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d required=%0d", name, bc, N + 1);
        end
        checks++;
        if (!ps) begin
            failures++;
            $display("FAIL %s_p_hold P changed during RUN, required hold of %0d", name, prev);
        end
        @(negedge clk);
        checks++;
        if (p_out !== exp_p || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle P=%0d busy=%b done=%b required P=%0d busy=0 done=0",
                     name, p_out, busy, done, exp_p);
        end
    endtask

    task automatic test_reset_mid_run();
        launch(4'd9, 4'd6, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (p_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_run_reset P=%0d busy=%b done=%b required 0 0 0", p_out, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (p_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL after_abort P=%0d busy=%b done=%b required 0 0 0", p_out, busy, done);
        end
        test_op("rerun_9x6", 4'd9, 4'd6, 1'b0);
    endtask

    // start held high: each done pulse arms the next operands before the next accept.
    task automatic test_back_to_back();
        logic [N-1:0]   av [3];
        logic [N-1:0]   bv [3];
        int             idx [3];
        logic [2*N-1:0] got [3];
        int k;
        av[0] = 4'd14; bv[0] = 4'd3;
        av[1] = 4'd4;  bv[1] = 4'd3;
        av[2] = 4'd15; bv[2] = 4'd1;
        k = 0;
        launch(av[0], bv[0], 1'b1);
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            if (done) begin
                idx[k] = c;
                got[k] = p_out;
                k++;
                if (k < 3) begin
                    a_in = av[k];
                    b_in = bv[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (k != 3) begin
            failures++;
            $display("FAIL b2b_count done_pulses=%0d required=3", k);
        end
        for (int i = 0; i < k; i++) begin
            checks++;
            if (got[i] !== (2*N)'(int'(av[i]) * int'(bv[i])) || idx[i] != int'(N) + i * (int'(N) + 2)) begin
                failures++;
                $display("FAIL b2b_op%0d P=%0d at_cycle=%0d required P=%0d at %0d", i, got[i], idx[i],
                         int'(av[i]) * int'(bv[i]), int'(N) + i * (int'(N) + 2));
            end
        end
        repeat (3) @(negedge clk);
    endtask

    // Rebuild a dividend from quotient and divisor: S*B + R.
    task automatic test_divider_crosscheck();
        int bc, dc, di;
        logic [2*N-1:0] pd;
        bit ps;
        int dividend;
        launch(4'd4, 4'd3, 1'b0);
        observe(1'b0, p_out, bc, dc, di, pd, ps);
        dividend = int'(pd) + 2;
        checks++;
        if (dividend != 14) begin
            failures++;
            $display("FAIL divider_crosscheck dividend=%0d required=14", dividend);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = N'($urandom_range(0, 15));
            b = N'($urandom_range(0, 15));
            test_op("random", a, b, 1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        test_reset();
        test_op("basic_14x3", 4'd14, 4'd3, 1'b0);
        test_op("max_15x15", 4'd15, 4'd15, 1'b0);
        test_op("zero_0x9", 4'd0, 4'd9, 1'b0);
        test_op("ignored_start_5x4", 4'd5, 4'd4, 1'b1);
        test_reset_mid_run();
        test_back_to_back();
        test_divider_crosscheck();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, required completion before 200000");
        $fatal(1);
    end

endmodule : tb_multiplicador_seq
